// File: rtl/hv_rac_scan_rsp.sv
// HV-die register-access responder: arbitrates watchdog-scan reads and OWT reads/writes
// onto a single-beat register-file port and returns ack, data and CRC-8 to the owner.
module hv_rac_scan_rsp #(
    parameter int REG_AW         = 7,
    parameter int REG_DW         = 8,
    parameter int REG_CRC_W      = 8,
    parameter int SCAN_STARVE_TH = 8,
    parameter int STV_CNT_W      = $clog2(SCAN_STARVE_TH + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_wdg_scan_rac_rd_req,
    input  logic [REG_AW-1:0]    i_wdg_scan_rac_addr,
    output logic                 o_rac_wdg_scan_ack,
    output logic [REG_DW-1:0]    o_rac_wdg_scan_data,
    output logic [REG_CRC_W-1:0] o_rac_wdg_scan_crc,
    input  logic                 i_owt_rac_wr_req,
    input  logic                 i_owt_rac_rd_req,
    input  logic [REG_AW-1:0]    i_owt_rac_addr,
    input  logic [REG_DW-1:0]    i_owt_rac_wdata,
    output logic                 o_rac_owt_ack,
    output logic [REG_DW-1:0]    o_rac_owt_rdata,
    output logic [REG_CRC_W-1:0] o_rac_owt_crc,
    output logic                 o_owt_req_err,
    input  logic                 i_scan_crc_inj,
    output logic                 o_rf_rd_en,
    output logic                 o_rf_wr_en,
    output logic [REG_AW-1:0]    o_rf_addr,
    output logic [REG_DW-1:0]    o_rf_wdata,
    input  logic [REG_DW-1:0]    i_rf_rdata
);
    localparam int MSG_W = REG_AW + REG_DW + 1;
    localparam logic [REG_CRC_W-1:0] CRC_POLY = REG_CRC_W'(8'h07);
    localparam logic [STV_CNT_W-1:0] STV_MAX  = STV_CNT_W'(SCAN_STARVE_TH);

    typedef enum logic [1:0] {IDLE, ACC, RDW, RSP} state_t;

    state_t                 state_q, state_d;
    logic                   own_scan_q, own_scan_d;
    logic                   is_wr_q, is_wr_d;
    logic                   err_q, err_d;
    logic [REG_AW-1:0]      addr_q, addr_d;
    logic [REG_DW-1:0]      wdata_q, wdata_d;
    logic [STV_CNT_W-1:0]   stv_cnt_q, stv_cnt_d;
    logic [REG_DW-1:0]      scan_data_q, scan_data_d;
    logic [REG_CRC_W-1:0]   scan_crc_q, scan_crc_d;
    logic [REG_DW-1:0]      owt_rdata_q, owt_rdata_d;
    logic [REG_CRC_W-1:0]   owt_crc_q, owt_crc_d;
    logic                   owt_req, scan_win;
    logic [REG_CRC_W-1:0]   crc_res;

    // MSB-first CRC (poly x^8+x^2+x+1, init 0), fully unrolled into XOR logic.
    function automatic logic [REG_CRC_W-1:0] crc16to8_parallel(input logic [MSG_W-1:0] msg);
        logic [REG_CRC_W-1:0] c;
        logic                 fb;
        c = '0;
        for (int i = MSG_W - 1; i >= 0; i--) begin
            fb = c[REG_CRC_W-1] ^ msg[i];
            c  = {c[REG_CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
        return c;
    endfunction

    assign owt_req  = i_owt_rac_wr_req | i_owt_rac_rd_req;
    assign scan_win = i_wdg_scan_rac_rd_req & (~owt_req | (stv_cnt_q == STV_MAX));
    assign crc_res  = crc16to8_parallel({1'b1, addr_q, i_rf_rdata});

    always_comb begin
        state_d     = state_q;
        own_scan_d  = own_scan_q;
        is_wr_d     = is_wr_q;
        err_d       = err_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        stv_cnt_d   = i_wdg_scan_rac_rd_req ? stv_cnt_q : '0;
        scan_data_d = scan_data_q;
        scan_crc_d  = scan_crc_q;
        owt_rdata_d = owt_rdata_q;
        owt_crc_d   = owt_crc_q;
        case (state_q)
            IDLE: begin
                if (owt_req | i_wdg_scan_rac_rd_req) begin
                    state_d    = ACC;
                    own_scan_d = scan_win;
                    // Simultaneous OWT rd+wr is served as a write and flagged.
                    is_wr_d    = ~scan_win & i_owt_rac_wr_req;
                    err_d      = ~scan_win & i_owt_rac_wr_req & i_owt_rac_rd_req;
                    addr_d     = scan_win ? i_wdg_scan_rac_addr : i_owt_rac_addr;
                    wdata_d    = i_owt_rac_wdata;
                    if (scan_win) begin
                        stv_cnt_d = '0;
                    end else if (i_wdg_scan_rac_rd_req && stv_cnt_q != STV_MAX) begin
                        stv_cnt_d = stv_cnt_q + 1'b1;
                    end
                end
            end
            ACC: state_d = is_wr_q ? RSP : RDW;
            RDW: begin
                state_d = RSP;
                if (own_scan_q) begin
                    scan_data_d = i_rf_rdata;
                    scan_crc_d  = crc_res ^ {{(REG_CRC_W-1){1'b0}}, i_scan_crc_inj};
                end else begin
                    owt_rdata_d = i_rf_rdata;
                    owt_crc_d   = crc_res;
                end
            end
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            own_scan_q  <= 1'b0;
            is_wr_q     <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            stv_cnt_q   <= '0;
            scan_data_q <= '0;
            scan_crc_q  <= '0;
            owt_rdata_q <= '0;
            owt_crc_q   <= '0;
        end else begin
            state_q     <= state_d;
            own_scan_q  <= own_scan_d;
            is_wr_q     <= is_wr_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            stv_cnt_q   <= stv_cnt_d;
            scan_data_q <= scan_data_d;
            scan_crc_q  <= scan_crc_d;
            owt_rdata_q <= owt_rdata_d;
            owt_crc_q   <= owt_crc_d;
        end
    end

    assign o_rf_rd_en          = (state_q == ACC) & ~is_wr_q;
    assign o_rf_wr_en          = (state_q == ACC) & is_wr_q;
    assign o_rf_addr           = addr_q;
    assign o_rf_wdata          = wdata_q;
    assign o_owt_req_err       = (state_q == ACC) & err_q;
    assign o_rac_wdg_scan_ack  = (state_q == RSP) & own_scan_q;
    assign o_rac_owt_ack       = (state_q == RSP) & ~own_scan_q;
    assign o_rac_wdg_scan_data = scan_data_q;
    assign o_rac_wdg_scan_crc  = scan_crc_q;
    assign o_rac_owt_rdata     = owt_rdata_q;
    assign o_rac_owt_crc       = owt_crc_q;
endmodule

// File: tb/tb_hv_rac_scan_rsp.sv
// Scoreboard bench for hv_rac_scan_rsp: drivers push expected responses, a monitor checks acks.
module tb_hv_rac_scan_rsp;
    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       scan_req, owt_wr, owt_rd, inj;
    logic [6:0] scan_addr, owt_addr;
    logic [7:0] owt_wdata;
    logic       scan_ack, owt_ack, req_err, rf_rd_en, rf_wr_en;
    logic [7:0] scan_data, scan_crc, owt_rdata, owt_crc, rf_wdata;
    logic [6:0] rf_addr;
    logic [7:0] i_rf_rdata;

    hv_rac_scan_rsp dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_wdg_scan_rac_rd_req(scan_req), .i_wdg_scan_rac_addr(scan_addr),
        .o_rac_wdg_scan_ack(scan_ack), .o_rac_wdg_scan_data(scan_data), .o_rac_wdg_scan_crc(scan_crc),
        .i_owt_rac_wr_req(owt_wr), .i_owt_rac_rd_req(owt_rd),
        .i_owt_rac_addr(owt_addr), .i_owt_rac_wdata(owt_wdata),
        .o_rac_owt_ack(owt_ack), .o_rac_owt_rdata(owt_rdata), .o_rac_owt_crc(owt_crc),
        .o_owt_req_err(req_err), .i_scan_crc_inj(inj),
        .o_rf_rd_en(rf_rd_en), .o_rf_wr_en(rf_wr_en), .o_rf_addr(rf_addr),
        .o_rf_wdata(rf_wdata), .i_rf_rdata(i_rf_rdata)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { logic [7:0] data; logic [7:0] crc; } exp_t;
    exp_t scan_q[$];
    exp_t owt_q[$];
    int   total = 0;
    int   bad   = 0;
    int   err_cnt = 0;
    logic [7:0] ref_mem [128];
    logic [7:0] rf_mem  [128];
    logic       rf_init;
    logic [7:0] owt_last_data, owt_last_crc;

    function automatic logic [7:0] pat(input int i);
        return (i == 'h50) ? 8'hA5 : 8'(i * 37 + 11);
    endfunction

    // Reference CRC by polynomial long division of {1,addr,data}*x^8 by 0x107.
    function automatic logic [7:0] ref_crc(input logic [6:0] a, input logic [7:0] d);
        logic [23:0] v;
        v = {1'b1, a, d, 8'h00};
        for (int i = 23; i >= 8; i--)
            if (v[i]) v[i-:9] = v[i-:9] ^ 9'h107;
        return v[7:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Register-file model: read data appears the cycle after the strobe.
    always @(posedge i_clk) begin
        if (rf_init) begin
            for (int i = 0; i < 128; i++) rf_mem[i] <= pat(i);
        end else begin
            if (rf_wr_en) rf_mem[rf_addr] <= rf_wdata;
            if (rf_rd_en) i_rf_rdata <= rf_mem[rf_addr];
        end
    end

    always @(negedge i_clk) begin
        exp_t e;
        if (req_err) err_cnt++;
        if (scan_ack) begin
            if (scan_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_scan_ack: got 1 want 0");
            end else begin
                e = scan_q.pop_front();
                chk("scan_data", scan_data, e.data);
                chk("scan_crc", scan_crc, e.crc);
            end
        end
        if (owt_ack) begin
            if (owt_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_owt_ack: got 1 want 0");
            end else begin
                e = owt_q.pop_front();
                chk("owt_rdata", owt_rdata, e.data);
                chk("owt_crc", owt_crc, e.crc);
            end
        end
    end

    function automatic void push_exp(input bit is_scan, input bit wr, input logic [6:0] a,
                                     input logic [7:0] wd, input bit inj_v);
        exp_t e;
        if (is_scan) begin
            e.data = ref_mem[a];
            e.crc  = ref_crc(a, ref_mem[a]) ^ {7'b0, inj_v};
            scan_q.push_back(e);
        end else if (wr) begin
            ref_mem[a] = wd;
            e.data = owt_last_data;
            e.crc  = owt_last_crc;
            owt_q.push_back(e);
        end else begin
            owt_last_data = ref_mem[a];
            owt_last_crc  = ref_crc(a, ref_mem[a]);
            e.data = owt_last_data;
            e.crc  = owt_last_crc;
            owt_q.push_back(e);
        end
    endfunction

    // Issue one transaction, wait (bounded) for its ack, drop the request at the ack edge.
    task automatic do_txn(input bit is_scan, input bit rd, input bit wr, input logic [6:0] a,
                          input logic [7:0] wd, input int exp_lat, input string nm);
        int n;
        bit got;
        push_exp(is_scan, wr, a, wd, inj);
        if (is_scan) begin
            scan_req = 1'b1; scan_addr = a;
        end else begin
            owt_rd = rd; owt_wr = wr; owt_addr = a; owt_wdata = wd;
        end
        n = 0; got = 0;
        while (!got && n <= 200) begin
            @(negedge i_clk);
            if (is_scan ? scan_ack : owt_ack) got = 1;
            else n++;
        end
        if (!got) chk({nm, "_timeout"}, 0, 1);
        else if (exp_lat >= 0) chk({nm, "_latency"}, n, exp_lat);
        @(posedge i_clk); #1;
        if (is_scan) scan_req = 1'b0;
        else begin owt_rd = 1'b0; owt_wr = 1'b0; end
    endtask

    // OWT writes kept back-to-back: the request level never drops between transactions.
    task automatic owt_burst(input int cnt);
        int n;
        bit got;
        for (int k = 0; k < cnt; k++) begin
            owt_addr = 7'h60 + 7'(k); owt_wdata = 8'($urandom); owt_wr = 1'b1; owt_rd = 1'b0;
            push_exp(1'b0, 1'b1, owt_addr, owt_wdata, 1'b0);
            n = 0; got = 0;
            while (!got && n <= 200) begin
                @(negedge i_clk);
                if (owt_ack) got = 1; else n++;
            end
            if (!got) chk("burst_timeout", 0, 1);
            @(posedge i_clk); #1;
        end
        owt_wr = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int e0;
        scan_req = 0; owt_wr = 0; owt_rd = 0; inj = 0;
        scan_addr = 0; owt_addr = 0; owt_wdata = 0;
        owt_last_data = 0; owt_last_crc = 0;
        for (int i = 0; i < 128; i++) ref_mem[i] = pat(i);
        rf_init = 1; i_rst_n = 0;
        #1;
        chk("reset_outputs", {scan_ack, scan_data, scan_crc, owt_ack, owt_rdata, owt_crc,
                              req_err, rf_rd_en, rf_wr_en, rf_addr, rf_wdata}, 0);
        repeat (3) @(posedge i_clk);
        #1 rf_init = 0; i_rst_n = 1;
        @(posedge i_clk); #1;

        // Scan read of 0x50, strobe and address at cycle 1.
        fork
            do_txn(1, 1, 0, 7'h50, 8'h00, 3, "scan_rd50");
            begin
                @(negedge i_clk); @(negedge i_clk);
                chk("rd_en_c1", {rf_rd_en, rf_wr_en, rf_addr}, {2'b10, 7'h50});
            end
        join
        // OWT write 0x09 <- 0x3C.
        fork
            do_txn(0, 0, 1, 7'h09, 8'h3C, 2, "owt_wr09");
            begin
                @(negedge i_clk); @(negedge i_clk);
                chk("wr_en_c1", {rf_rd_en, rf_wr_en, rf_addr, rf_wdata}, {2'b01, 7'h09, 8'h3C});
            end
        join
        chk("rf_written_09", rf_mem[9], 8'h3C);
        // Simultaneous OWT read and scan read.
        fork
            do_txn(1, 1, 0, 7'h21, 8'h00, 7, "scan_after_owt");
            do_txn(0, 1, 0, 7'h09, 8'h00, 3, "owt_first");
        join
        // Starvation: two rounds show the counter restarts from 0.
        for (int r = 0; r < 2; r++) begin
            fork
                do_txn(1, 1, 0, 7'h10, 8'h00, 8 * 3 + 3, "scan_starve");
                owt_burst(10);
            join
        end
        // CRC fault injection on scan acks.
        inj = 1; do_txn(1, 1, 0, 7'h01, 8'h00, 3, "scan_inj1");
        inj = 0; do_txn(1, 1, 0, 7'h01, 8'h00, 3, "scan_inj0");
        // OWT rd and wr both high: write wins, error pulses once.
        e0 = err_cnt;
        do_txn(0, 1, 1, 7'h33, 8'hC7, 2, "owt_rdwr");
        chk("req_err_pulses", err_cnt - e0, 1);
        chk("rf_written_33", rf_mem[7'h33], 8'hC7);
        // Reset asserted during RDW.
        push_exp(1, 0, 7'h44, 8'h00, 1'b0);
        scan_req = 1; scan_addr = 7'h44;
        repeat (3) @(negedge i_clk);
        i_rst_n = 0;
        #1;
        chk("rst_mid_outputs", {scan_ack, scan_data, scan_crc, owt_ack, owt_rdata, owt_crc,
                                req_err, rf_rd_en, rf_wr_en, rf_addr, rf_wdata}, 0);
        void'(scan_q.pop_back());
        owt_last_data = 0; owt_last_crc = 0;
        @(posedge i_clk); #1 scan_req = 0;
        @(posedge i_clk); #1 i_rst_n = 1;
        repeat (3) @(posedge i_clk); #1;
        do_txn(1, 1, 0, 7'h44, 8'h00, 3, "scan_after_rst");
        do_txn(0, 1, 0, 7'h50, 8'h00, 3, "owt_after_rst");
        // Random single transactions.
        for (int k = 0; k < 40; k++) begin
            int kind;
            logic [6:0] a;
            logic [7:0] d;
            kind = $urandom_range(0, 2);
            a = 7'($urandom);
            d = 8'($urandom);
            inj = (kind == 0) ? 1'($urandom) : 1'b0;
            case (kind)
                0: do_txn(1, 1, 0, a, d, 3, "rnd_scan");
                1: do_txn(0, 1, 0, a, d, 3, "rnd_owt_rd");
                default: do_txn(0, 0, 1, a, d, 2, "rnd_owt_wr");
            endcase
        end
        inj = 0;
        repeat (5) @(posedge i_clk);
        chk("scan_q_drained", scan_q.size(), 0);
        chk("owt_q_drained", owt_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
